// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder/subtractor.
//   BCD_W      : bits per BCD digit
//   state_t    : control FSM states (IDLE, RUN, DONE)
//   nines_comp : 9 - digit, used to turn subtraction into addition
//   is_bcd     : 1 when a nibble is a legal decimal digit (0..9)
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Non-BCD inputs wrap modulo 16; the result stays X-free.
    function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] digit);
        return 4'd9 - digit;
    endfunction

    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Combinational single-digit decimal adder.
//   a_d   : first operand digit
//   bd    : second operand digit (already nines-complemented for subtract)
//   c     : carry-in
//   digit : decimal sum digit
//   carry : decimal carry-out
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a_d,
    input  logic [BCD_W-1:0] bd,
    input  logic             c,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    logic [BCD_W:0] s;
    logic [BCD_W:0] s_adj;

    // Five bits wide so 15+15+1 from non-BCD nibbles cannot overflow.
    assign s     = {1'b0, a_d} + {1'b0, bd} + {{BCD_W{1'b0}}, c};
    assign s_adj = s + 5'd6;

    always_comb begin
        digit = s[BCD_W-1:0];
        carry = 1'b0;
        if (s > 5'd9) begin
            digit = s_adj[BCD_W-1:0];
            carry = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// N-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional build macro: BCD_CHECK_EN (flags non-BCD operand nibbles on err).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, sub, cin)
//   a, b                : packed BCD operands, digit 0 in bits [3:0]
//   sub                 : 0 = a + b, 1 = a - b
//   cin                 : add carry-in / subtract borrow-in
//   out_valid/out_ready : result handshake (sum, cout, err)
//   sum                 : packed BCD result (modulo 10^DIGITS)
//   cout                : add carry-out / subtract 1 = no borrow
//   busy                : FSM not in IDLE
//   err                 : non-BCD nibble seen at acceptance
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    input  logic                    sub,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] sum,
    output logic                    cout,
    output logic                    busy,
    output logic                    err
);

    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [W-1:0]     sum_r;
    logic             sub_r;
    logic             carry_r;
    logic             cout_r;
    logic [IDX_W-1:0] idx;

    logic [BCD_W-1:0] a_d;
    logic [BCD_W-1:0] b_d;
    logic [BCD_W-1:0] bd;
    logic [BCD_W-1:0] digit;
    logic             digit_carry;
    logic             accept;
    logic             take;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    assign a_d = a_r[idx*BCD_W +: BCD_W];
    assign b_d = b_r[idx*BCD_W +: BCD_W];
    assign bd  = sub_r ? nines_comp(b_d) : b_d;

    bcd_digit_cell u_cell (
        .a_d   (a_d),
        .bd    (bd),
        .c     (carry_r),
        .digit (digit),
        .carry (digit_carry)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    if (take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            idx     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r     <= a;
                        b_r     <= b;
                        sub_r   <= sub;
                        // Subtract is a + (nines complement of b) + 1 - borrow.
                        carry_r <= sub ? !cin : cin;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_r[idx*BCD_W +: BCD_W] <= digit;
                    carry_r <= digit_carry;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) cout_r <= digit_carry;
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_CHECK_EN
    logic operands_bad;
    logic err_r;

    always_comb begin
        operands_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!is_bcd(a[i*BCD_W +: BCD_W]) || !is_bcd(b[i*BCD_W +: BCD_W]))
                operands_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (accept) begin
            err_r <= operands_bad;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed self-checking bench for bcd_serial_addsub (DIGITS=4).
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Present operands, wait for acceptance, then count edges until out_valid.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tsub, input logic tcin, output int lat);
        int n;
        a = ta; b = tb_v; sub = tsub; cin = tcin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        logic [15:0] va [4] = '{16'h1234, 16'h9999, 16'h0000, 16'h0450};
        logic [15:0] vb [4] = '{16'h5678, 16'h0001, 16'h0000, 16'h0550};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] es [4] = '{16'h6912, 16'h0000, 16'h0001, 16'h1000};
        logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 1'b0, vc[i], lat);
            checks++; if (lat != 4) begin errors++; $display("FAIL add_latency[%0d] got=%0d exp=4", i, lat); end
            checks++; if (sum !== es[i]) begin errors++; $display("FAIL add_sum[%0d] got=%h exp=%h", i, sum, es[i]); end
            checks++; if (cout !== ec[i]) begin errors++; $display("FAIL add_cout[%0d] got=%b exp=%b", i, cout, ec[i]); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err[%0d] got=%b exp=0", i, err); end
            finish_op();
        end
    endtask

    task automatic test_sub();
        logic [15:0] va [3] = '{16'h5000, 16'h0100, 16'h0005};
        logic [15:0] vb [3] = '{16'h1234, 16'h0200, 16'h0005};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] es [3] = '{16'h3766, 16'h9900, 16'h9999};
        logic        ec [3] = '{1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], 1'b1, vc[i], lat);
            checks++; if (lat != 4) begin errors++; $display("FAIL sub_latency[%0d] got=%0d exp=4", i, lat); end
            checks++; if (sum !== es[i]) begin errors++; $display("FAIL sub_sum[%0d] got=%h exp=%h", i, sum, es[i]); end
            checks++; if (cout !== ec[i]) begin errors++; $display("FAIL sub_cout[%0d] got=%b exp=%b", i, cout, ec[i]); end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(16'h0808, 16'h0303, 1'b0, 1'b0, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        // Offer a competing operand while the result is held.
        a = 16'h1111; b = 16'h2222; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (sum !== 16'h1111) begin errors++; $display("FAIL bp_sum[%0d] got=%h exp=1111", i, sum); end
            checks++; if (cout !== 1'b0) begin errors++; $display("FAIL bp_cout[%0d] got=%b exp=0", i, cout); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
        end
        in_valid = 1'b0;
        finish_op();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;                 // acceptance edge k
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_accept_busy got=%b exp=1", busy); end
        repeat (2) @(posedge clk);          // edges k+1, k+2
        #1;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_out_valid got=%b exp=0", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL mid_fresh_latency got=%0d exp=4", lat); end
        checks++; if (sum !== 16'h0002) begin errors++; $display("FAIL mid_fresh_sum got=%h exp=0002", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL mid_fresh_cout got=%b exp=0", cout); end
        finish_op();
    endtask

`ifdef BCD_CHECK_EN
    task automatic test_bcd_check();
        int lat;
        do_op(16'h00A0, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL chk_err_set got=%b exp=1", err); end
        checks++; if (sum !== 16'h0101) begin errors++; $display("FAIL chk_bad_sum got=%h exp=0101", sum); end
        finish_op();
        do_op(16'h0010, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_err_clear got=%b exp=0", err); end
        checks++; if (sum !== 16'h0011) begin errors++; $display("FAIL chk_good_sum got=%h exp=0011", sum); end
        finish_op();
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
`ifdef BCD_CHECK_EN
        test_bcd_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
